// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1-to-2 stream demultiplexer.
// Holds the alternation state enum, default widths and the destination helper.
package demux_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // Alternation state: which channel the next round-robin word goes to.
    typedef enum logic {
        NEXT0 = 1'b0,
        NEXT1 = 1'b1
    } alt_state_e;

    // Destination channel: in_sel in steer mode, alternation state otherwise.
    function automatic logic pick_dest(
        input logic       mode,
        input logic       sel,
        input alt_state_e st
    );
        return mode ? (st == NEXT1) : sel;
    endfunction

endpackage

// File: rtl/out_slot.sv
// One output channel: a single-entry register, its valid flag and a
// wrapping count of accepted words.
// Ports: clk, rst_n (async, active-low); load_i/data_i capture a word;
// ready_i pops it; valid_o/data_o present it; free_o = slot can take a word;
// cnt_o = words accepted so far.
module out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             free_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // A word leaving this cycle frees the slot for a same-cycle refill.
    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux1to2_stream.sv
// 1-to-2 valid/ready stream demultiplexer, steer or round-robin, latency 1.
// Ports: clk, rst_n; in_valid/in_ready/in_data/in_sel upstream; mode
// (0 steer, 1 alternate); outK_valid/ready/data downstream; cntK counters.
module demux1to2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             mode,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    alt_state_e state_q, state_d;
    logic       dest;
    logic       free0, free1;
    logic       in_fire;
    logic       load0, load1;

    assign dest     = pick_dest(mode, in_sel, state_q);
    // Only the destination slot gates acceptance; the other may stall freely.
    assign in_ready = dest ? free1 : free0;
    assign in_fire  = in_valid && in_ready;
    assign load0    = in_fire && !dest;
    assign load1    = in_fire && dest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NEXT0;
        end else begin
            state_q <= state_d;
        end
    end

    // State only advances on round-robin transfers; kept across steer periods.
    always_comb begin
        state_d = state_q;
        if (in_fire && mode) begin
            state_d = (state_q == NEXT0) ? NEXT1 : NEXT0;
        end
    end

    out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load0),
        .data_i  (in_data),
        .ready_i (out0_ready),
        .valid_o (out0_valid),
        .data_o  (out0_data),
        .free_o  (free0),
        .cnt_o   (cnt0)
    );

    out_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load1),
        .data_i  (in_data),
        .ready_i (out1_ready),
        .valid_o (out1_valid),
        .data_o  (out1_data),
        .free_o  (free1),
        .cnt_o   (cnt1)
    );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_demux1to2_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       mode;
    logic       out0_valid, out1_valid;
    logic       out0_ready, out1_ready;
    logic [7:0] out0_data, out1_data;
    logic [7:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    demux1to2_stream #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .mode       (mode),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic m, input logic s, input logic [7:0] d);
        mode     = m;
        in_sel   = s;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_sel     = 1'b0;
        mode       = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

        // Reset state, before any clock edge
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_v0", out0_valid, 0);
        check("rst_v1", out1_valid, 0);
        check("rst_d0", out0_data, 0);
        check("rst_d1", out1_data, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Steer a single word to out1
        send(1'b0, 1'b1, 8'hA5);
        check("st_v1", out1_valid, 1);
        check("st_d1", out1_data, 8'hA5);
        check("st_v0", out0_valid, 0);
        check("st_cnt1", cnt1, 1);
        check("st_cnt0", cnt0, 0);
        tick();
        check("st_drain_v1", out1_valid, 0);

        // Round-robin, back-to-back, 1 word/cycle
        do_reset();
        mode     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        check("rr1_v0", out0_valid, 1);
        check("rr1_d0", out0_data, 8'h01);
        check("rr1_v1", out1_valid, 0);
        check("rr2_rdy", in_ready, 1);
        in_data = 8'h02;
        tick();
        check("rr2_v1", out1_valid, 1);
        check("rr2_d1", out1_data, 8'h02);
        check("rr2_v0", out0_valid, 0);
        in_data = 8'h03;
        tick();
        check("rr3_v0", out0_valid, 1);
        check("rr3_d0", out0_data, 8'h03);
        in_data = 8'h04;
        tick();
        check("rr4_v1", out1_valid, 1);
        check("rr4_d1", out1_data, 8'h04);
        in_valid = 1'b0;
        check("rr_cnt0", cnt0, 2);
        check("rr_cnt1", cnt1, 2);
        tick();

        // Stall on out0 blocks out0 traffic only
        out0_ready = 1'b0;
        send(1'b0, 1'b0, 8'h11);
        check("stl_v0", out0_valid, 1);
        check("stl_d0", out0_data, 8'h11);
        mode     = 1'b0;
        in_sel   = 1'b0;
        in_data  = 8'h22;
        in_valid = 1'b1;
        #1;
        check("stl_rdy0", in_ready, 0);
        tick();
        check("stl_hold_d0", out0_data, 8'h11);
        check("stl_hold_v0", out0_valid, 1);
        check("stl_cnt0", cnt0, 3);
        in_sel  = 1'b1;
        in_data = 8'h33;
        #1;
        check("stl_rdy1", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("stl_v1", out1_valid, 1);
        check("stl_d1", out1_data, 8'h33);
        check("stl_d0b", out0_data, 8'h11);
        check("stl_cnt1", cnt1, 3);

        // Pop and refill out0 in the same cycle
        out0_ready = 1'b1;
        mode       = 1'b0;
        in_sel     = 1'b0;
        in_data    = 8'h5A;
        in_valid   = 1'b1;
        #1;
        check("pr_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("pr_v0", out0_valid, 1);
        check("pr_d0", out0_data, 8'h5A);
        check("pr_cnt0", cnt0, 4);
        check("pr_v1", out1_valid, 0);

        // 256 words to out0: counter wraps
        do_reset();
        mode     = 1'b0;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            tick();
            if (i == 254) check("wr_cnt255", cnt0, 255);
        end
        in_valid = 1'b0;
        check("wr_cnt0", cnt0, 0);
        check("wr_cnt1", cnt1, 0);
        check("wr_last", out0_data, 8'hFF);

        // Asynchronous reset mid-stream
        tick();
        out0_ready = 1'b0;
        send(1'b1, 1'b0, 8'h66);
        check("ar_pre_v0", out0_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_v0", out0_valid, 0);
        check("ar_v1", out1_valid, 0);
        check("ar_d0", out0_data, 0);
        check("ar_cnt0", cnt0, 0);
        check("ar_rdy", in_ready, 1);
        mode     = 1'b1;
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick();
        check("ar_nocap_v0", out0_valid, 0);
        check("ar_nocap_v1", out1_valid, 0);
        in_valid = 1'b0;
        #3;
        rst_n      = 1'b1;
        out0_ready = 1'b1;
        tick();
        send(1'b1, 1'b0, 8'h77);
        check("ar_post_v0", out0_valid, 1);
        check("ar_post_d0", out0_data, 8'h77);
        check("ar_post_v1", out1_valid, 0);

        // Alternation state retained across a steer period
        send(1'b0, 1'b0, 8'h88);
        check("ret_d0", out0_data, 8'h88);
        check("ret_v1a", out1_valid, 0);
        send(1'b1, 1'b0, 8'h99);
        check("ret_v1", out1_valid, 1);
        check("ret_d1", out1_data, 8'h99);
        check("ret_v0", out0_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1to2_stream.md
DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-channel transfer counter.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts the upstream word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream word.
REQ-008 SHALL have port in_sel  input  1  destination in steer mode: 0 selects out0, 1 selects out1.
REQ-009 SHALL have port mode  input  1  0 means steer by in_sel; 1 means alternate (round-robin).
REQ-010 SHALL have ports out0_valid / out1_valid  output  1  channel holds a word.
REQ-011 SHALL have ports out0_ready / out1_ready  input  1  downstream takes the word.
REQ-012 SHALL have ports out0_data / out1_data  output  WIDTH  channel word.
REQ-013 SHALL have ports cnt0 / cnt1  output  CNT_W  count of words accepted per channel.

Function
REQ-014 SHALL define input transfer as in_valid && in_ready, and output transfer on channel k as outk_valid && outk_ready, each sampled at the clk edge.
REQ-015 SHALL form the destination dest as in_sel when mode=0, and as the alternation state when mode=1.
REQ-016 SHALL give each channel a one-entry output register; on an input transfer, in_data SHALL appear on out[dest]_data with out[dest]_valid=1 in the next cycle (latency 1).
REQ-017 SHALL drive in_ready combinationally as (!out[dest]_valid || out[dest]_ready), with no combinational dependence on in_valid.
REQ-018 SHALL allow pop and refill of the same channel in one cycle, sustaining 1 word/cycle when outk_ready is held at 1.
REQ-019 SHALL hold outk_data stable and outk_valid high while outk_valid=1 and outk_ready=0; a stall on one channel SHALL NOT block input traffic destined for the other channel.
REQ-020 SHALL clear outk_valid after an output transfer if no refill occurs in the same cycle.
REQ-021 SHALL use an alternation FSM with states NEXT0 and NEXT1: it moves to the other state only on an input transfer while mode=1, and otherwise holds its state.
REQ-022 SHALL let a mode change take effect in the same cycle, with no flush; the FSM state SHALL be retained across mode=0 periods.
REQ-023 SHALL increment cntk by 1 on each input transfer with dest=k, wrapping from 2^CNT_W-1 to 0, with no saturation.
REQ-024 SHALL ignore in_data and in_sel when in_valid=0; outk_data SHALL be undefined-don't-care while outk_valid=0 but SHALL be deterministic (reset to 0).

Reset
REQ-025 SHALL, on rst_n=0 and independent of clk, force out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0 and FSM=NEXT0.
REQ-026 SHALL discard all buffered words on reset mid-operation, with no output transfer reported in that cycle.
REQ-027 SHALL drive in_ready as 1 while in reset, since both slots are empty, but no transfer SHALL be captured until the first clk edge with rst_n=1.

Structure
REQ-028 SHALL place the FSM state enum (NEXT0, NEXT1) and the default WIDTH/CNT_W constants in shared package demux_pkg.
REQ-029 SHALL implement each channel's register, valid flag and counter as sub-module out_slot, instantiated twice.

Verification
REQ-030 SHALL cover: reset, then mode=0, in_sel=1, in_data=8'hA5, one cycle valid, both ready=1 -> next cycle out1_valid=1, out1_data=A5, out0_valid=0, cnt1=1.
REQ-031 SHALL cover: mode=1, words 01,02,03,04 back-to-back, ready=1 -> out0 receives 01 and 03, out1 receives 02 and 04, 1 word/cycle, cnt0=cnt1=2.
REQ-032 SHALL cover: out0_ready=0 with out0 full, in_sel=0 -> in_ready=0 and out0_data held; switch in_sel=1 -> in_ready=1 and the word routes to out1.
REQ-033 SHALL cover: out0 full, out0_ready=1, new in_sel=0 word 5A in the same cycle -> out0_valid stays 1, out0_data=5A next cycle, no bubble.
REQ-034 SHALL cover: 256 words to out0 with CNT_W=8 -> cnt0 wraps to 0.
REQ-035 SHALL cover: rst_n pulled low mid-stream between clk edges -> valids and counters 0 immediately, FSM=NEXT0; first post-reset mode=1 word goes to out0.
